// File: rtl/ped_tl_pkg.sv
// Shared definitions for the timed pedestrian crossing controller:
// one-hot state encoding, default phase durations and a duration range check.
package ped_tl_pkg;

  localparam logic [5:0] ST_T_GREEN  = 6'b000001;
  localparam logic [5:0] ST_T_YELLOW = 6'b000010;
  localparam logic [5:0] ST_CLR1     = 6'b000100;
  localparam logic [5:0] ST_P_WALK   = 6'b001000;
  localparam logic [5:0] ST_P_BLINK  = 6'b010000;
  localparam logic [5:0] ST_CLR2     = 6'b100000;

  typedef enum logic [5:0] {
    T_GREEN  = ST_T_GREEN,
    T_YELLOW = ST_T_YELLOW,
    CLR1     = ST_CLR1,
    P_WALK   = ST_P_WALK,
    P_BLINK  = ST_P_BLINK,
    CLR2     = ST_CLR2
  } state_t;

  localparam int CNT_W_DEF     = 8;
  localparam int GREEN_MIN_DEF = 10;
  localparam int YELLOW_T_DEF  = 3;
  localparam int CLR_T_DEF     = 2;
  localparam int WALK_T_DEF    = 8;
  localparam int BLINK_T_DEF   = 4;

  // A phase of length d loads d-1, so d must lie in 1..2^w.
  function automatic bit dur_ok(input int d, input int w);
    return (d >= 1) && (longint'(d) <= (longint'(1) << w));
  endfunction

endpackage

// File: rtl/ped_tl_timer.sv
// Phase timer: loads a value, counts down once per cycle and saturates at zero.
module ped_tl_timer #(
  parameter int               TP      = 1,
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] timer,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= #TP RST_VAL;
    end else if (load) begin
      cnt <= #TP load_val;
    end else if (cnt != '0) begin
      cnt <= #TP cnt - CNT_W'(1);
    end
  end

  assign timer = cnt;
  assign zero  = (cnt == '0);

endmodule

// File: rtl/ped_traffic_light_timed.sv
// Pedestrian crossing controller: traffic green held until a request is pending,
// then yellow, all-red, walk, blinking walk, all-red, and back to green.
module ped_traffic_light_timed
  import ped_tl_pkg::*;
#(
  parameter int TP        = 1,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int CLR_T     = CLR_T_DEF,
  parameter int WALK_T    = WALK_T_DEF,
  parameter int BLINK_T   = BLINK_T_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  output logic             traff_green,
  output logic             traff_yellow,
  output logic             traff_red,
  output logic             ped_green,
  output logic             ped_red,
  output logic [CNT_W-1:0] ped_timer,
  output logic             req_pending
);

  if (!dur_ok(GREEN_MIN, CNT_W) || !dur_ok(YELLOW_T, CNT_W) || !dur_ok(CLR_T, CNT_W) ||
      !dur_ok(WALK_T, CNT_W) || !dur_ok(BLINK_T, CNT_W)) begin : g_bad_duration
    $error("ped_traffic_light_timed: phase duration must be in 1..2^CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LD_CLR    = CNT_W'(CLR_T - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] LD_BLINK  = CNT_W'(BLINK_T - 1);

  state_t           state, state_nxt;
  logic             req_q, req_nxt;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] timer;
  logic             timer_zero;

  ped_tl_timer #(
    .TP      (TP),
    .CNT_W   (CNT_W),
    .RST_VAL (LD_GREEN)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .timer    (timer),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= #TP T_GREEN;
      req_q <= #TP 1'b0;
    end else begin
      state <= #TP state_nxt;
      req_q <= #TP req_nxt;
    end
  end

  // Every transition reloads the timer with the duration of the state being entered.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = LD_GREEN;
    case (state)
      T_GREEN: begin
        if (timer_zero && (req_q || btn)) begin
          state_nxt = T_YELLOW;
          load      = 1'b1;
          load_val  = LD_YELLOW;
        end
      end
      T_YELLOW: begin
        if (timer_zero) begin
          state_nxt = CLR1;
          load      = 1'b1;
          load_val  = LD_CLR;
        end
      end
      CLR1: begin
        if (timer_zero) begin
          state_nxt = P_WALK;
          load      = 1'b1;
          load_val  = LD_WALK;
        end
      end
      P_WALK: begin
        if (timer_zero) begin
          state_nxt = P_BLINK;
          load      = 1'b1;
          load_val  = LD_BLINK;
        end
      end
      P_BLINK: begin
        if (timer_zero) begin
          state_nxt = CLR2;
          load      = 1'b1;
          load_val  = LD_CLR;
        end
      end
      CLR2: begin
        if (timer_zero) begin
          state_nxt = T_GREEN;
          load      = 1'b1;
          load_val  = LD_GREEN;
        end
      end
      default: begin
        state_nxt = T_GREEN;
        load      = 1'b1;
        load_val  = LD_GREEN;
      end
    endcase
  end

  // Entering the walk phase serves the request and beats a same-cycle press.
  always_comb begin
    req_nxt = req_q | btn;
    if (load && (state_nxt == P_WALK)) begin
      req_nxt = 1'b0;
    end
  end

  assign traff_green  = (state == T_GREEN);
  assign traff_yellow = (state == T_YELLOW);
  assign traff_red    = (state == CLR1) || (state == P_WALK) ||
                        (state == P_BLINK) || (state == CLR2);
  assign ped_green    = (state == P_WALK) || ((state == P_BLINK) && !timer[0]);
  assign ped_red      = (state == T_GREEN) || (state == T_YELLOW) ||
                        (state == CLR1) || (state == CLR2);
  assign ped_timer    = timer;
  assign req_pending  = req_q;

endmodule

// File: tb/tb_ped_traffic_light_timed.sv
// Scoreboard bench for ped_traffic_light_timed: directed scenarios push expected
// per-cycle lamp/timer/request vectors; a negedge monitor pops and compares them.
module tb_ped_traffic_light_timed;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;

  logic       tg, ty, tr, pg, pr, rq;
  logic [7:0] pt;
  logic       b_tg, b_ty, b_tr, b_pg, b_pr, b_rq;
  logic [7:0] b_pt;

  ped_traffic_light_timed dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .traff_green  (tg),
    .traff_yellow (ty),
    .traff_red    (tr),
    .ped_green    (pg),
    .ped_red      (pr),
    .ped_timer    (pt),
    .req_pending  (rq)
  );

  ped_traffic_light_timed #(.GREEN_MIN(1), .BLINK_T(1)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .traff_green  (b_tg),
    .traff_yellow (b_ty),
    .traff_red    (b_tr),
    .ped_green    (b_pg),
    .ped_red      (b_pr),
    .ped_timer    (b_pt),
    .req_pending  (b_rq)
  );

  always #5 clk = ~clk;

  // Lamp codes {traff_green, traff_yellow, traff_red, ped_green, ped_red}
  localparam logic [4:0] L_G  = 5'b10001;
  localparam logic [4:0] L_Y  = 5'b01001;
  localparam logic [4:0] L_C  = 5'b00101;
  localparam logic [4:0] L_W  = 5'b00110;
  localparam logic [4:0] L_BO = 5'b00100;

  typedef struct {
    int         cyc;
    bit         rst;
    logic [13:0] v;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic seg(input int s, input int n, input logic [4:0] lamps, input int t0, input bit r);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.cyc = s + i;
      e.rst = 1'b0;
      e.v   = {lamps, r, 8'((t0 - i < 0) ? 0 : t0 - i)};
      sbq.push_back(e);
    end
  endtask

  task automatic rst_exp();
    exp_t e;
    e.cyc = 0;
    e.rst = 1'b1;
    e.v   = {L_G, 1'b0, 8'd9};
    sbq.push_back(e);
  endtask

  // Monitor: invariants on both instances, then scoreboard pops.
  always @(negedge clk) begin
    logic [13:0] act;
    exp_t e;
    act = {tg, ty, tr, pg, pr, rq, pt};
    n_cmp = n_cmp + 2;
    if ((32'(tg) + 32'(ty) + 32'(tr)) != 1 || (pg && tg)) begin
      n_err++;
      $display("FAIL invariant dut t=%0t got tg/ty/tr/pg=%b%b%b%b want one traffic lamp, no pg&tg", $time, tg, ty, tr, pg);
    end
    if ((32'(b_tg) + 32'(b_ty) + 32'(b_tr)) != 1 || (b_pg && b_tg)) begin
      n_err++;
      $display("FAIL invariant dut_b t=%0t got tg/ty/tr/pg=%b%b%b%b want one traffic lamp, no pg&tg", $time, b_tg, b_ty, b_tr, b_pg);
    end
    while (sbq.size() > 0) begin
      e = sbq[0];
      if (e.rst == !rst_n && e.cyc == cyc) begin
        n_cmp++;
        if (act !== e.v) begin
          n_err++;
          $display("FAIL outputs cyc=%0d rst=%0d got lamps=%b req=%b timer=%0d want lamps=%b req=%b timer=%0d",
                   cyc, e.rst, act[13:9], act[8], act[7:0], e.v[13:9], e.v[8], e.v[7:0]);
        end
        void'(sbq.pop_front());
      end else if (e.rst == !rst_n && e.cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missed cyc=%0d got no sample want expectation for cyc %0d", cyc, e.cyc);
        void'(sbq.pop_front());
      end else begin
        break;
      end
    end
  end

  task automatic do_reset();
    btn   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Drive btn=1 during cycles b0..b1 (cycle 0 = first cycle after reset release).
  task automatic run(input int n, input int b0, input int b1);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1 btn = (c >= b0) && (c <= b1);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain %s got %0d pending expectations want 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // S1: single press at cycle 2, full rotation back to green.
    rst_exp();
    seg(0, 3, L_G, 9, 0);   seg(3, 7, L_G, 6, 1);
    seg(10, 3, L_Y, 2, 1);  seg(13, 2, L_C, 1, 1);
    seg(15, 8, L_W, 7, 0);
    seg(23, 1, L_BO, 3, 0); seg(24, 1, L_W, 2, 0);
    seg(25, 1, L_BO, 1, 0); seg(26, 1, L_W, 0, 0);
    seg(27, 2, L_C, 1, 0);  seg(29, 10, L_G, 9, 0);
    seg(39, 3, L_G, 0, 0);
    do_reset();
    run(42, 2, 2);
    drain("s1");

    // S2: no request, green holds with saturated timer.
    rst_exp();
    seg(0, 10, L_G, 9, 0);  seg(10, 40, L_G, 0, 0);
    do_reset();
    run(50, 99, -1);
    drain("s2");

    // S3: first press on a cycle where the green timer is already zero.
    rst_exp();
    seg(0, 10, L_G, 9, 0);  seg(10, 11, L_G, 0, 0);
    seg(21, 3, L_Y, 2, 1);  seg(24, 2, L_C, 1, 1);
    seg(26, 1, L_W, 7, 0);
    do_reset();
    run(27, 20, 20);
    drain("s3");

    // S4: button held; clear wins at walk entry, next green is exactly GREEN_MIN.
    rst_exp();
    seg(0, 1, L_G, 9, 0);   seg(1, 9, L_G, 8, 1);
    seg(10, 3, L_Y, 2, 1);  seg(13, 2, L_C, 1, 1);
    seg(15, 1, L_W, 7, 0);  seg(16, 7, L_W, 6, 1);
    seg(23, 1, L_BO, 3, 1); seg(24, 1, L_W, 2, 1);
    seg(25, 1, L_BO, 1, 1); seg(26, 1, L_W, 0, 1);
    seg(27, 2, L_C, 1, 1);  seg(29, 10, L_G, 9, 1);
    seg(39, 1, L_Y, 2, 1);
    do_reset();
    run(40, 0, 39);
    drain("s4");

    // S5: reset during walk aborts straight to green.
    rst_exp();
    seg(0, 1, L_G, 9, 0);   seg(1, 9, L_G, 8, 1);
    seg(10, 3, L_Y, 2, 1);  seg(13, 2, L_C, 1, 1);
    seg(15, 3, L_W, 7, 0);
    rst_exp();
    seg(0, 2, L_G, 9, 0);
    do_reset();
    run(18, 0, 0);
    do_reset();
    run(2, 99, -1);
    drain("s5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ped_traffic_light_timed.md
PED_TRAFFIC_LIGHT_TIMED -- requirements
Module: ped_traffic_light_timed

Interface
REQ-001 The block SHALL have parameter TP, default 1, register-update propagation delay applied to every sequential assignment.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the phase timer.
REQ-003 The block SHALL have parameter GREEN_MIN, default 10, minimum traffic-green phase length in clk cycles.
REQ-004 The block SHALL have parameter YELLOW_T, default 3, traffic-yellow phase length in cycles.
REQ-005 The block SHALL have parameter CLR_T, default 2, all-red clearance length in cycles.
REQ-006 The block SHALL have parameter WALK_T, default 8, steady pedestrian-green length in cycles.
REQ-007 The block SHALL have parameter BLINK_T, default 4, blinking pedestrian-green length in cycles.
REQ-008 Port clk, input, 1 bit: one clock, 1 Hz tick (1 cycle = 1 s); every flop is rising-edge on it.
REQ-009 Port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-010 Port btn, input, 1 bit: pedestrian request button, synchronous to clk, level-sampled.
REQ-011 Ports traff_green, traff_yellow, traff_red, output, 1 bit each: traffic lamps.
REQ-012 Ports ped_green, ped_red, output, 1 bit each: pedestrian lamps.
REQ-013 Port ped_timer, output, CNT_W bits: cycles remaining in the current phase, minus one.
REQ-014 Port req_pending, output, 1 bit: a latched pedestrian request awaits service.

Function
REQ-015 The FSM SHALL have six one-hot states: T_GREEN, T_YELLOW, CLR1, P_WALK, P_BLINK, CLR2.
REQ-016 On entry into a state of duration D, the timer SHALL load D-1 and decrement by 1 per cycle.
REQ-017 Phase durations: T_YELLOW=YELLOW_T, CLR1=CLR2=CLR_T, P_WALK=WALK_T, P_BLINK=BLINK_T.
REQ-018 T_GREEN SHALL load GREEN_MIN-1 and hold at 0 once reached (saturate, no wrap).
REQ-019 Timed states SHALL advance when timer==0, in order T_YELLOW->CLR1->P_WALK->P_BLINK->CLR2->T_GREEN, so each state lasts exactly D cycles.
REQ-020 T_GREEN SHALL advance to T_YELLOW on the first cycle where timer==0 and (req_pending or btn)=1.
REQ-021 req_pending SHALL set on any cycle with btn=1 and clear on the cycle P_WALK is entered.
REQ-022 If set and clear coincide, clear SHALL win; presses during P_WALK, P_BLINK or CLR2 SHALL set req_pending for the next cycle.
REQ-023 Lamp decode (Moore, from state register):
- traff_green: T_GREEN
- traff_yellow: T_YELLOW
- traff_red: CLR1, P_WALK, P_BLINK, CLR2
- ped_green: P_WALK, plus P_BLINK while timer[0]==0
- ped_red: T_GREEN, T_YELLOW, CLR1, CLR2
REQ-024 Exactly one traffic lamp SHALL be on every cycle.
REQ-025 ped_green and traff_green SHALL never both be 1.
REQ-026 ped_timer SHALL equal the internal timer value.
REQ-027 Elaboration SHALL fail if any duration is 0 or exceeds 2^CNT_W.

Reset
REQ-028 While rst_n=0, asynchronously:
- state=T_GREEN, timer=GREEN_MIN-1, req_pending=0
- outputs: traff_green=1, ped_red=1, all other lamps 0, ped_timer=GREEN_MIN-1
REQ-029 Reset asserted mid-phase (including P_WALK) SHALL abort the phase immediately, with no clearance.
REQ-030 The first edge after deassertion SHALL be treated as the first cycle of T_GREEN.

Structure
REQ-031 Shared package ped_tl_pkg SHALL hold the state encoding constants and the default duration constants.
REQ-032 The phase timer (load/decrement/saturate, zero flag) SHALL be sub-module ped_tl_timer; the FSM, request latch and lamp decode stay in the top.

Verification
REQ-033 Defaults, btn pulse at cycle 2 after reset -> yellow at cycle 10 for 3, clear 2, walk 8, blink 4 (ped_green 0,1,0,1), clear 2, green at cycle 29.
REQ-034 No btn for 50 cycles -> traff_green=1 throughout, ped_timer holds 0 from cycle 9.
REQ-035 btn first asserted on the cycle T_GREEN timer hits 0 (cycle 20, no prior request) -> T_YELLOW on the next cycle.
REQ-036 btn held high through an entire cycle -> req_pending=1 again after P_WALK entry; next green lasts exactly GREEN_MIN.
REQ-037 rst_n pulsed low during P_WALK -> immediate traff_green=1, ped_red=1, req_pending=0.
REQ-038 Checker every cycle: one traffic lamp on, never ped_green&traff_green; repeat with GREEN_MIN=1, BLINK_T=1.
